shift_register_file: RTL and testbench
======================================

SHIFT_REGISTER_FILE -- requirements
Module: shift_register_file

Interface
REQ-001 Parameter WIDTH, default 3, bit width of each entry; SHALL be >= 1.
REQ-002 Parameter DEPTH, default 8, number of entries; SHALL be a power of two >= 2.
REQ-003 Derived constant AW = log2(DEPTH), address width; SHALL not be overridable.
REQ-004 Clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Rst_n  input  1  asynchronous, active-low reset.
REQ-006 WriteData  input  WIDTH  data for port write.
REQ-007 WriteAddr  input  AW  entry written when WRF=1.
REQ-008 WRF  input  1  write enable.
REQ-009 DownShift  input  1  shift toward index 0 (entry i takes entry i+1).
REQ-010 UpShift  input  1  shift toward index DEPTH-1 (entry i takes entry i-1).
REQ-011 ShiftIn  input  WIDTH  value entering the vacated end on a shift.
REQ-012 Clr  input  1  start sequential bulk clear.
REQ-013 ReadAddrA, ReadAddrB  input  AW each  two independent read addresses.
REQ-014 ReadDataA, ReadDataB  output  WIDTH each  registered read data.
REQ-015 Busy  output  1  high while the clear sequence runs.
REQ-016 Done  output  1  one-cycle pulse when the clear sequence finishes.

Function
REQ-017 Controller SHALL have two states, IDLE and CLEAR; reset state is IDLE.
REQ-018 In IDLE, per edge: shift first, then write; a write lands on the post-shift array and wins over the shifted value at WriteAddr.
REQ-019 DownShift=1, UpShift=0: entry i <= entry i+1 for i = 0..DEPTH-2; entry DEPTH-1 <= ShiftIn.
REQ-020 UpShift=1, DownShift=0: entry i <= entry i-1 for i = 1..DEPTH-1; entry 0 <= ShiftIn.
REQ-021 DownShift=1 and UpShift=1 together: no shift occurs; WRF still honoured.
REQ-022 Clr=1 in IDLE SHALL move to CLEAR on the same edge, load clear index to 0, and take priority over WRF and shifts that cycle (neither is applied).
REQ-023 In CLEAR: one entry (clear index) zeroed per edge, index increments; WRF, DownShift, UpShift, Clr ignored.
REQ-024 Entry DEPTH-1 zeroed on the DEPTH-th CLEAR edge; on that edge state returns to IDLE and Done is asserted for exactly the following cycle.
REQ-025 Busy SHALL equal (state == CLEAR); it is high for exactly DEPTH cycles per clear.
REQ-026 Clear index SHALL wrap naturally at AW bits; no out-of-range access is possible.
REQ-027 ReadDataX SHALL be registered every edge, in all states, from the next-state value of entry ReadAddrX (write-through: a write or shift on edge k is visible at ReadDataX after edge k).
REQ-028 Read latency is one clock from ReadAddrX change to ReadDataX update; no combinational path from inputs to outputs.

Reset
REQ-029 Rst_n low SHALL immediately (asynchronously) zero all entries, ReadDataA, ReadDataB, Done, Busy, clear index, and force IDLE.
REQ-030 Reset asserted mid-clear SHALL abort the sequence with no Done pulse.
REQ-031 First state update after Rst_n deassertion occurs on the first rising edge with Rst_n high.

Structure
REQ-032 Shared package SHALL hold the state encoding (IDLE, CLEAR) and default WIDTH/DEPTH constants.
REQ-033 Clear sequencer (state, index, Busy, Done) SHALL be a sub-module named rf_clear_ctrl; storage, shift and read logic stay in shift_register_file.

Verification (WIDTH=3, DEPTH=8 unless stated)
REQ-034 Reset, then write 2@0, 5@1, 7@3; ReadAddrA=3, ReadAddrB=1 -> ReadDataA=7, ReadDataB=5 one edge later.
REQ-035 From REQ-034 state, DownShift=1 with ShiftIn=4 for one edge -> entries 0..7 = 5,0,7,0,0,0,0,4.
REQ-036 Same edge: UpShift=1, ShiftIn=6, WRF=1 writing 3@0 -> entry 0 = 3, entry 1 = old entry 0; with both shifts high -> only the write applies.
REQ-037 Fill all entries with 7, pulse Clr -> Busy high 8 cycles, entries zero in index order, Done high one cycle, WRF during Busy has no effect.
REQ-038 Rst_n low at third CLEAR cycle, between edges -> all outputs 0 immediately, state IDLE, no Done.
REQ-039 WIDTH=8, DEPTH=16: write 0xA5@15, UpShift with ShiftIn=0x3C -> entry 15 = old entry 14, entry 0 = 0x3C, 0xA5 lost.

Source files
------------

// File: rtl/shift_register_file_pkg.sv
// Shared types and defaults for the shift register file.
// Holds the clear-controller state encoding.
package shift_register_file_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 3;
    localparam int DEF_DEPTH = 8;

endpackage

// File: rtl/shift_register_file_if.sv
// Port bundle for the shift register file.
// The master drives control and data; the slave returns reads and status.
interface shift_register_file_if
    import shift_register_file_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] write_data;
    logic [AW-1:0]    write_addr;
    logic             wrf;
    logic             down_shift;
    logic             up_shift;
    logic [WIDTH-1:0] shift_in;
    logic             clr;
    logic [AW-1:0]    read_addr_a;
    logic [AW-1:0]    read_addr_b;
    logic [WIDTH-1:0] read_data_a;
    logic [WIDTH-1:0] read_data_b;
    logic             busy;
    logic             done;

    modport master (
        output write_data, write_addr, wrf,
        output down_shift, up_shift, shift_in,
        output clr, read_addr_a, read_addr_b,
        input  read_data_a, read_data_b,
        input  busy, done
    );

    modport slave (
        input  write_data, write_addr, wrf,
        input  down_shift, up_shift, shift_in,
        input  clr, read_addr_a, read_addr_b,
        output read_data_a, read_data_b,
        output busy, done
    );

endinterface

// File: rtl/rf_clear_ctrl.sv
// Sequential bulk-clear controller: walks an index over every
// entry once, raising busy throughout and pulsing done at the end.
module rf_clear_ctrl
    import shift_register_file_pkg::*;
#(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] idx
);

    state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (clr) begin
                        state <= CLEAR;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    idx <= idx + 1'b1;
                    // last entry zeroed this edge
                    if (&idx) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_register_file.sv
// Shiftable register file with two registered read ports
// and a sequential bulk clear.
module shift_register_file
    import shift_register_file_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input logic                 clk,
    input logic                 rst_n,
    shift_register_file_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] nxt [DEPTH];
    logic             clearing;
    logic [AW-1:0]    clr_idx;
    logic             shift_dn;
    logic             shift_up;

    rf_clear_ctrl #(
        .AW(AW)
    ) u_clear_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clr),
        .busy  (clearing),
        .done  (bus.done),
        .idx   (clr_idx)
    );

    assign bus.busy = clearing;
    assign shift_dn = bus.down_shift & ~bus.up_shift;
    assign shift_up = bus.up_shift & ~bus.down_shift;

    // Shift first, then the port write overrides its target.
    always_comb begin
        nxt = mem;
        if (clearing) begin
            nxt[clr_idx] = '0;
        end else if (!bus.clr) begin
            unique case (1'b1)
                shift_dn: begin
                    for (int i = 0; i < DEPTH - 1; i++)
                        nxt[i] = mem[i+1];
                    nxt[DEPTH-1] = bus.shift_in;
                end
                shift_up: begin
                    for (int i = 1; i < DEPTH; i++)
                        nxt[i] = mem[i-1];
                    nxt[0] = bus.shift_in;
                end
                default: ;
            endcase
            if (bus.wrf)
                nxt[bus.write_addr] = bus.write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            bus.read_data_a <= '0;
            bus.read_data_b <= '0;
        end else begin
            mem             <= nxt;
            bus.read_data_a <= nxt[bus.read_addr_a];
            bus.read_data_b <= nxt[bus.read_addr_b];
        end
    end

endmodule

// File: tb/tb_shift_register_file.sv
// Scoreboard bench for shift_register_file: an 8x3 and a 16x8
// instance share control stimulus and are checked against a model.
module tb_shift_register_file;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wrf, ds, us, clr;
    logic [7:0] wd, si;
    logic [3:0] wa, ra, rb;

    shift_register_file_if #(.WIDTH(3), .DEPTH(8))  bus0 ();
    shift_register_file_if #(.WIDTH(8), .DEPTH(16)) bus1 ();

    assign bus0.write_data  = wd[2:0];
    assign bus0.write_addr  = wa[2:0];
    assign bus0.wrf         = wrf;
    assign bus0.down_shift  = ds;
    assign bus0.up_shift    = us;
    assign bus0.shift_in    = si[2:0];
    assign bus0.clr         = clr;
    assign bus0.read_addr_a = ra[2:0];
    assign bus0.read_addr_b = rb[2:0];

    assign bus1.write_data  = wd;
    assign bus1.write_addr  = wa;
    assign bus1.wrf         = wrf;
    assign bus1.down_shift  = ds;
    assign bus1.up_shift    = us;
    assign bus1.shift_in    = si;
    assign bus1.clr         = clr;
    assign bus1.read_addr_a = ra;
    assign bus1.read_addr_b = rb;

    shift_register_file #(.WIDTH(3), .DEPTH(8)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    shift_register_file #(.WIDTH(8), .DEPTH(16)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        bit busy;
        bit done;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   mem[2][16];
    int   cl_left[2];
    int   cl_idx[2];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   mon_on = 1'b0;
    int   exp035[8] = '{5, 0, 7, 0, 0, 0, 0, 4};

    function automatic void chk(string name, logic [31:0] got,
                                logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endfunction

    // Reference: array of integers plus a remaining-clear count.
    function automatic exp_t model(int k);
        int   d  = (k != 0) ? 16 : 8;
        int   m  = (k != 0) ? 255 : 7;
        int   am = d - 1;
        bit   dn = 1'b0;
        exp_t e;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[k][i] = 0;
            cl_left[k] = 0;
            cl_idx[k]  = 0;
        end else if (cl_left[k] > 0) begin
            mem[k][cl_idx[k]] = 0;
            cl_idx[k]  = (cl_idx[k] + 1) % d;
            cl_left[k] = cl_left[k] - 1;
            dn = (cl_left[k] == 0);
        end else if (clr) begin
            cl_left[k] = d;
            cl_idx[k]  = 0;
        end else begin
            if (ds && !us) begin
                for (int i = 0; i < d - 1; i++)
                    mem[k][i] = mem[k][i+1];
                mem[k][d-1] = int'(si) & m;
            end else if (us && !ds) begin
                for (int i = d - 1; i > 0; i--)
                    mem[k][i] = mem[k][i-1];
                mem[k][0] = int'(si) & m;
            end
            if (wrf) mem[k][int'(wa) & am] = int'(wd) & m;
        end
        e.a    = mem[k][int'(ra) & am];
        e.b    = mem[k][int'(rb) & am];
        e.busy = (cl_left[k] > 0);
        e.done = dn;
        return e;
    endfunction

    task automatic step();
        q0.push_back(model(0));
        q1.push_back(model(1));
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        if (mon_on) begin
            #1;
            if (q0.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb0 empty: got none expected entry");
            end else begin
                e0 = q0.pop_front();
                chk("i0 rda",  bus0.read_data_a, e0.a);
                chk("i0 rdb",  bus0.read_data_b, e0.b);
                chk("i0 busy", bus0.busy, e0.busy);
                chk("i0 done", bus0.done, e0.done);
            end
            if (q1.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb1 empty: got none expected entry");
            end else begin
                e1 = q1.pop_front();
                chk("i1 rda",  bus1.read_data_a, e1.a);
                chk("i1 rdb",  bus1.read_data_b, e1.b);
                chk("i1 busy", bus1.busy, e1.busy);
                chk("i1 done", bus1.done, e1.done);
            end
        end
    end

    initial begin
        wrf = 0; ds = 0; us = 0; clr = 0;
        wd = 0; si = 0; wa = 0; ra = 0; rb = 0;
        for (int k = 0; k < 2; k++) begin
            cl_left[k] = 0;
            cl_idx[k]  = 0;
            for (int i = 0; i < 16; i++) mem[k][i] = 0;
        end
        @(negedge clk);
        mon_on = 1'b1;
        step();
        step();
        chk("reset busy", bus0.busy, 0);
        chk("reset done", bus0.done, 0);
        chk("reset rda", bus0.read_data_a, 0);
        rst_n = 1'b1;

        // basic writes and dual reads
        wrf = 1; wa = 0; wd = 2; step();
        wa = 1; wd = 5; step();
        wa = 3; wd = 7; step();
        wrf = 0; ra = 3; rb = 1; step();
        chk("wr rda", bus0.read_data_a, 7);
        chk("wr rdb", bus0.read_data_b, 5);
        chk("wr i1 rda", bus1.read_data_a, 7);

        // down shift
        ds = 1; si = 4; step();
        ds = 0;
        for (int i = 0; i < 8; i++) begin
            ra = 4'(i);
            step();
            chk("dshift entry", bus0.read_data_a, exp035[i]);
        end

        // up shift with write, then both shifts with write
        us = 1; si = 6; wrf = 1; wa = 0; wd = 3;
        ra = 0; rb = 1; step();
        chk("ushift wr e0", bus0.read_data_a, 3);
        chk("ushift wr e1", bus0.read_data_b, 5);
        ds = 1; wa = 2; wd = 1; ra = 2; rb = 1; step();
        chk("both wr e2", bus0.read_data_a, 1);
        chk("both e1", bus0.read_data_b, 5);
        ds = 0; us = 0; wrf = 0;

        // fill then bulk clear with writes attempted while busy
        wrf = 1; wd = 7;
        for (int i = 0; i < 16; i++) begin
            wa = 4'(i);
            step();
        end
        wrf = 0;
        clr = 1; step();
        clr = 0;
        chk("clr busy", bus0.busy, 1);
        wrf = 1; wa = 0; wd = 1;
        for (int j = 0; j < 8; j++) begin
            ra = 4'(j);
            rb = 4'((j + 1) % 8);
            step();
            chk("clr zero", bus0.read_data_a, 0);
            chk("clr next", bus0.read_data_b, (j < 7) ? 7 : 0);
            chk("clr busy run", bus0.busy, (j < 7) ? 1 : 0);
            chk("clr done", bus0.done, (j == 7) ? 1 : 0);
        end
        wrf = 0; ra = 0; step();
        chk("done pulse end", bus0.done, 0);
        chk("wr ignored", bus0.read_data_a, 0);
        repeat (10) step();

        // reset in the middle of a clear
        wrf = 1; wd = 6;
        for (int i = 0; i < 16; i++) begin
            wa = 4'(i);
            step();
        end
        wrf = 0; ra = 5; rb = 12;
        clr = 1; step();
        clr = 0; step(); step();
        chk("mid busy", bus0.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("async busy", bus0.busy, 0);
        chk("async done", bus0.done, 0);
        chk("async rda", bus0.read_data_a, 0);
        chk("async rdb", bus0.read_data_b, 0);
        chk("async i1 rdb", bus1.read_data_b, 0);
        step();
        rst_n = 1'b1;
        repeat (20) step();
        chk("no done", bus0.done, 0);

        // 16x8 instance: top entry lost on up shift
        wrf = 1; wa = 14; wd = 8'h11; step();
        wa = 15; wd = 8'hA5; step();
        wrf = 0;
        us = 1; si = 8'h3C; ra = 15; rb = 0; step();
        us = 0;
        chk("wide e15", bus1.read_data_a, 8'h11);
        chk("wide e0", bus1.read_data_b, 8'h3C);

        // randomized traffic
        repeat (600) begin
            rst_n = ($urandom_range(0, 99) != 0);
            clr   = ($urandom_range(0, 29) == 0);
            ds    = ($urandom_range(0, 3) == 0);
            us    = ($urandom_range(0, 3) == 0);
            wrf   = ($urandom_range(0, 1) == 1);
            wd    = 8'($urandom);
            si    = 8'($urandom);
            wa    = 4'($urandom);
            ra    = 4'($urandom);
            rb    = 4'($urandom);
            step();
        end
        rst_n = 1'b1; clr = 0; wrf = 0; ds = 0; us = 0;
        step();
        mon_on = 1'b0;
        @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
